// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register bank.
// FSM state encoding and frame command bit values.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_e;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for one asynchronous pin plus a third
// flop for rise/fall detection; RST_VAL is the pin's idle level.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], pin_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {3{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank: R/W bit, address, data frames.
// Define SPI_READBACK_EN to build the read shift path onto CIPO.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       SCLK,
  input  logic                       COPI,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int F     = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(F + 1);
  localparam logic [ADDR_W:0] NREG = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;

  spi_sync #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .pin_i(SCLK),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync #(.RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst(rst), .pin_i(COPI),
    .level_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst(rst), .pin_i(nCS),
    .level_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               commit, err;
  logic               addr_ok;

  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic               wr_strobe_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic               frame_err_q;

  assign addr_ok = {1'b0, addr_q} < NREG;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= CMD_READ;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // nCS rise takes priority over any SCLK edge seen in the same clk
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    commit  = 1'b0;
    err     = 1'b0;
    if (ncs_rise) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      unique case (state_q)
        ST_DONE: begin
          if (rw_q == CMD_WRITE) begin
            commit = addr_ok;
            err    = ~addr_ok;
          end
        end
        ST_CMD, ST_ADDR, ST_DATA: err = 1'b1;
        default: ;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ncs_fall) begin
            state_d = ST_CMD;
            cnt_d   = '0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            rw_d    = copi_lvl;
            addr_d  = '0;
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            addr_d = (addr_q << 1) | ADDR_W'(copi_lvl);
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ADDR_W)) begin
              data_d  = '0;
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            data_d = (data_q << 1) | DATA_W'(copi_lvl);
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(F - 1)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      wr_strobe_q <= commit;
      frame_err_q <= err;
      if (commit) begin
        wr_addr_q <= addr_q;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (addr_q == ADDR_W'(k)) begin
            regs_q[k] <= data_q;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_sh_q;
  logic              cipo_q;
  logic              load_rd;

  assign load_rd = (state_q == ST_ADDR) && sclk_rise && !ncs_rise &&
                   (cnt_q == CNT_W'(ADDR_W));

  // Unmatched addresses fall through to zero
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addr_d == ADDR_W'(k)) begin
        rd_word = regs_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sh_q <= '0;
      cipo_q  <= 1'b0;
    end else if (load_rd) begin
      rd_sh_q <= (rw_q == CMD_READ) ? rd_word : '0;
      cipo_q  <= 1'b0;
    end else if ((state_q == ST_DATA) && sclk_fall && !ncs_rise) begin
      cipo_q  <= rd_sh_q[DATA_W-1];
      rd_sh_q <= rd_sh_q << 1;
    end
  end

  assign CIPO = cipo_q && (state_q == ST_DATA) && (rw_q == CMD_READ);
`else
  assign CIPO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed table-driven bench for spi_reg_bank (default parameters).
// Read data expectations follow SPI_READBACK_EN.
module tb_spi_reg_bank;

  localparam int H = 8;

`ifdef SPI_READBACK_EN
  localparam logic RB = 1'b1;
`else
  localparam logic RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SCLK = 1'b0;
  logic        COPI = 1'b0;
  logic        nCS = 1'b1;
  logic        CIPO;
  logic [39:0] regs;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic        frame_err;

  spi_reg_bank dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
    .CIPO(CIPO), .regs(regs), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int stb_tot = 0;
  int err_tot = 0;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) stb_tot++;
    if (frame_err === 1'b1) err_tot++;
  end

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  data;
    int          nbits;
    int          exp_stb;
    int          exp_err;
    logic [6:0]  exp_wa;
    logic [39:0] exp_regs;
    logic [7:0]  exp_rx;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic rw, input logic [6:0] a,
                           input logic [7:0] d, input int nbits,
                           input bit keep_cs, output logic [7:0] rx);
    logic [15:0] w;
    w  = {rw, a, d};
    rx = '0;
    nCS = 1'b0;
    repeat (H) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      COPI = (i < 16) ? w[15-i] : 1'b0;
      repeat (H) @(posedge clk);
      #1;
      if (i >= 8 && i < 16) rx = {rx[6:0], CIPO};
      SCLK = 1'b1;
      repeat (H) @(posedge clk);
      SCLK = 1'b0;
    end
    if (!keep_cs) begin
      repeat (H) @(posedge clk);
      nCS = 1'b1;
      repeat (12) @(posedge clk);
    end
  endtask

  initial begin
    logic [7:0] rx;
    int s0, e0;

    vt[0] = '{1'b1, 7'd2, 8'hA5, 16, 1, 0, 7'd2,
              40'h00_00_A5_00_00, 8'h00};
    vt[1] = '{1'b1, 7'd5, 8'h3C, 16, 0, 1, 7'd2,
              40'h00_00_A5_00_00, 8'h00};
    vt[2] = '{1'b1, 7'd1, 8'h5A, 16, 1, 0, 7'd1,
              40'h00_00_A5_5A_00, 8'h00};
    vt[3] = '{1'b0, 7'd1, 8'h00, 16, 0, 0, 7'd1,
              40'h00_00_A5_5A_00, RB ? 8'h5A : 8'h00};
    vt[4] = '{1'b1, 7'd0, 8'hFF, 10, 0, 1, 7'd1,
              40'h00_00_A5_5A_00, 8'h00};
    vt[5] = '{1'b1, 7'd3, 8'h11, 20, 1, 0, 7'd3,
              40'h00_11_A5_5A_00, 8'h00};
    vt[6] = '{1'b1, 7'd0, 8'h42, 16, 1, 0, 7'd0,
              40'h00_11_A5_5A_42, 8'h00};
    vt[7] = '{1'b0, 7'd6, 8'h00, 16, 0, 0, 7'd0,
              40'h00_11_A5_5A_42, 8'h00};
    vt[8] = '{1'b1, 7'd4, 8'h99, 16, 1, 0, 7'd4,
              40'h99_11_A5_5A_42, 8'h00};

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_regs", 64'(regs), 64'h0);
    chk("rst_wr_addr", 64'(wr_addr), 64'h0);
    chk("rst_cipo", 64'(CIPO), 64'h0);
    chk("rst_strobe", 64'(wr_strobe), 64'h0);
    chk("rst_ferr", 64'(frame_err), 64'h0);
    @(posedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    for (int v = 0; v < 9; v++) begin
      s0 = stb_tot;
      e0 = err_tot;
      run_frame(vt[v].rw, vt[v].addr, vt[v].data, vt[v].nbits, 1'b0, rx);
      @(negedge clk);
      chk($sformatf("v%0d_strobe", v), 64'(stb_tot - s0), 64'(vt[v].exp_stb));
      chk($sformatf("v%0d_ferr", v), 64'(err_tot - e0), 64'(vt[v].exp_err));
      chk($sformatf("v%0d_wr_addr", v), 64'(wr_addr), 64'(vt[v].exp_wa));
      chk($sformatf("v%0d_regs", v), 64'(regs), 64'(vt[v].exp_regs));
      chk($sformatf("v%0d_rx", v), 64'(rx), 64'(vt[v].exp_rx));
      chk($sformatf("v%0d_cipo_idle", v), 64'(CIPO), 64'h0);
    end

    // Reset arrives after 12 bits of a write; the frame must vanish
    s0 = stb_tot;
    e0 = err_tot;
    run_frame(1'b1, 7'd0, 8'hEE, 12, 1'b1, rx);
    @(posedge clk);
    rst = 1'b1;
    nCS = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midrst_regs_in_rst", 64'(regs), 64'h0);
    @(posedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midrst_regs", 64'(regs), 64'h0);
    chk("midrst_wr_addr", 64'(wr_addr), 64'h0);
    chk("midrst_strobe", 64'(stb_tot - s0), 64'h0);
    chk("midrst_ferr", 64'(err_tot - e0), 64'h0);
    chk("midrst_cipo", 64'(CIPO), 64'h0);

    s0 = stb_tot;
    e0 = err_tot;
    run_frame(1'b1, 7'd0, 8'h77, 16, 1'b0, rx);
    @(negedge clk);
    chk("post_rst_regs", 64'(regs), 64'h77);
    chk("post_rst_wr_addr", 64'(wr_addr), 64'h0);
    chk("post_rst_strobe", 64'(stb_tot - s0), 64'h1);
    chk("post_rst_ferr", 64'(err_tot - e0), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter NUM_REGS, default 5: number of DATA_W-bit registers, 1..2**ADDR_W.
REQ-002 Parameter ADDR_W, default 7: address field width in the frame.
REQ-003 Parameter DATA_W, default 8: register and data field width.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 SCLK, COPI, nCS  input  1 each  asynchronous SPI pins, mode 0, MSB first.
REQ-007 CIPO  output  1  serial read data.
REQ-008 regs  output  NUM_REGS*DATA_W  flat register image; register k occupies bits [k*DATA_W +: DATA_W].
REQ-009 wr_strobe  output  1  one-clk pulse on each committed write.
REQ-010 wr_addr  output  ADDR_W  address of the last committed write.
REQ-011 frame_err  output  1  one-clk pulse when a frame is discarded.

Function
REQ-012 SCLK, COPI and nCS SHALL each pass through a 2-FF synchroniser; a third FF SHALL provide edge detection. Pin edges become visible 3 clk after the pin changes.
REQ-013 Frame format SHALL be: 1 R/W bit (1 = write), ADDR_W address bits, then DATA_W data bits; total F = 1+ADDR_W+DATA_W bits.
REQ-014 COPI SHALL be sampled on each detected SCLK rise while nCS is low; a bit counter SHALL count 0..F.
REQ-015 FSM states: IDLE -> CMD on nCS fall; CMD -> ADDR after bit 0; ADDR -> DATA after ADDR_W bits; DATA -> DONE after DATA_W bits. Any state returns to IDLE on nCS rise.
REQ-016 DONE SHALL ignore further SCLK edges until nCS rises; exactly one frame per nCS assertion.
REQ-017 On nCS rise from DONE with write=1 and addr < NUM_REGS, the register SHALL update on the next clk edge, with wr_strobe high for that cycle and wr_addr = addr.
REQ-018 nCS rise in any state other than DONE, or a write with addr >= NUM_REGS, SHALL leave regs unchanged, assert no wr_strobe, and pulse frame_err for one clk.
REQ-019 For a read (R/W=0), the addressed register SHALL be loaded into a shift register once the address completes. Bit MSB SHALL drive CIPO after the next detected SCLK fall, shifting once per subsequent fall.
REQ-020 A read with addr >= NUM_REGS SHALL shift out zeros; a read SHALL never modify regs or pulse wr_strobe.
REQ-021 CIPO SHALL be 0 whenever the FSM is not in DATA of a read frame.
REQ-022 Simultaneous SCLK edge and nCS rise detections: nCS rise SHALL win; the SCLK edge is dropped.

Reset
REQ-023 While rst is high: FSM = IDLE, bit counter = 0, every regs bit = 0, wr_addr = 0, wr_strobe = 0, frame_err = 0, CIPO = 0, and synchroniser FFs load the idle level (SCLK 0, nCS 1).
REQ-024 Reset asserted mid-frame SHALL abort the frame with no commit; after release the block SHALL wait for a fresh nCS fall.

Configuration
REQ-025 Macro SPI_READBACK_EN defined: read frames behave per REQ-019..021.
REQ-026 SPI_READBACK_EN undefined: no read shift register is built; CIPO is tied 0; read frames are accepted and discarded silently (no frame_err).

Structure
REQ-027 Package spi_pkg SHALL hold the FSM state enum typedef and the CMD_WRITE/CMD_READ bit constants.
REQ-028 Sub-module spi_sync (2-FF synchroniser plus rise/fall detect, reset value as a parameter) SHALL be instantiated once per input pin.

Verification
REQ-029 Write 0xA5 to addr 2 -> after nCS rise, regs[23:16]=0xA5, wr_strobe one clk, wr_addr=2; other registers stay 0.
REQ-030 Write 0x3C to addr 5 with NUM_REGS=5 -> regs unchanged, frame_err one clk, no wr_strobe.
REQ-031 Write 0x5A to addr 1, then read addr 1 -> CIPO bits 0,1,0,1,1,0,1,0 on consecutive SCLK falls; with SPI_READBACK_EN undefined, CIPO stays 0.
REQ-032 nCS rises after 10 of 16 bits of a write 0xFF to addr 0 -> regs[7:0] stays 0, frame_err pulses; next full frame writes correctly.
REQ-033 20 SCLK pulses in one write 0x11 to addr 3 -> extra bits ignored, regs[31:24]=0x11.
REQ-034 rst asserted after 12 bits of a write, then released -> all outputs 0; a following complete write 0x77 to addr 0 commits.
